// File: rtl/vx_gbar_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// vx_gbar_arbiter_pkg
// Shared definitions for the cluster global-barrier controller.
//   - GBAR_DEF_*     : default cluster geometry
//   - gbar_w()       : id/index width helper, never narrower than 1 bit
//   - gbar_req_t     : per-core barrier request payload (default geometry)
//   - gbar_rsp_t     : broadcast release payload (default geometry)
// -----------------------------------------------------------------------------
package vx_gbar_arbiter_pkg;

    // Width of an index into n items; a 1-entry space still needs a 1-bit field.
    function automatic int gbar_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int GBAR_DEF_NUM_CORES    = 4;
    localparam int GBAR_DEF_NUM_BARRIERS = 8;
    localparam int GBAR_DEF_PERF_BITS    = 44;
    localparam int GBAR_NB_WIDTH         = gbar_w(GBAR_DEF_NUM_BARRIERS);
    localparam int GBAR_NC_WIDTH         = gbar_w(GBAR_DEF_NUM_CORES);

    typedef struct packed {
        logic [GBAR_NB_WIDTH-1:0] id;
        logic [GBAR_NC_WIDTH-1:0] size_m1;
    } gbar_req_t;

    typedef struct packed {
        logic [GBAR_NB_WIDTH-1:0] id;
    } gbar_rsp_t;

endpackage

// File: rtl/vx_gbar_rr_arb.sv
// -----------------------------------------------------------------------------
// vx_gbar_rr_arb
// N-way round-robin arbiter, reusable for any cluster-shared resource.
// Ports:
//   clk, reset      : clock, asynchronous active-high reset
//   i_valid[N]      : requester valid vector
//   i_fire          : advance the pointer past the current grant
//   o_grant[N]      : one-hot grant (all zero when nothing is valid)
//   o_grant_idx     : index of the granted requester
//   o_grant_valid   : some requester is granted this cycle
// The search starts at the pointer and wraps; after a fire the pointer moves
// to the slot just past the winner, so every requester waits at most N-1
// grants.
// -----------------------------------------------------------------------------
module vx_gbar_rr_arb
    import vx_gbar_arbiter_pkg::*;
#(
    parameter int N  = 4,
    parameter int IW = gbar_w(N)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [N-1:0]  i_valid,
    input  logic          i_fire,
    output logic [N-1:0]  o_grant,
    output logic [IW-1:0] o_grant_idx,
    output logic          o_grant_valid
);

    logic [IW-1:0] r_ptr;

    always_comb begin
        int w_idx;
        w_idx         = 0;
        o_grant       = '0;
        o_grant_idx   = '0;
        o_grant_valid = 1'b0;
        for (int k = 0; k < N; k++) begin
            w_idx = int'(r_ptr) + k;
            if (w_idx >= N) w_idx = w_idx - N;
            if (!o_grant_valid && i_valid[w_idx]) begin
                o_grant_valid = 1'b1;
                o_grant_idx   = IW'(w_idx);
            end
        end
        if (o_grant_valid) o_grant[o_grant_idx] = 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ptr <= '0;
        end else if (i_fire) begin
            r_ptr <= (o_grant_idx == IW'(N - 1)) ? '0 : o_grant_idx + 1'b1;
        end
    end

endmodule

// File: rtl/vx_gbar_arbiter.sv
// -----------------------------------------------------------------------------
// vx_gbar_arbiter
// Cluster-level global barrier controller shared by all cores.
// Ports:
//   clk, reset          : clock, asynchronous active-high reset
//   req_valid[C]        : per-core barrier request valid
//   req_id[C*NB]        : per-core barrier id (core c at [c*NB +: NB])
//   req_size_m1[C*NC]   : per-core participating core count minus one
//   req_ready[C]        : per-core grant, at most one high per cycle
//   rsp_valid, rsp_id   : one-cycle release pulse broadcast to all cores
//   err_dup             : sticky, a core re-arrived at a barrier it already held
//   perf_releases,
//   perf_stall_cycles   : only when GBAR_PERF_EN is defined; wrapping counters
//                         of release pulses and of cycles with >1 requester
// Optional feature macro: GBAR_PERF_EN
// One request is accepted per cycle. Each barrier keeps a core-arrival mask;
// the arrival that brings the population up to size_m1+1 clears the mask and
// triggers the release on the following cycle. Only the completing request's
// size is looked at.
// -----------------------------------------------------------------------------
module vx_gbar_arbiter
    import vx_gbar_arbiter_pkg::*;
#(
    parameter int NUM_CORES     = GBAR_DEF_NUM_CORES,
    parameter int NUM_BARRIERS  = GBAR_DEF_NUM_BARRIERS,
    parameter int NB_WIDTH      = gbar_w(NUM_BARRIERS),
    parameter int NC_WIDTH      = gbar_w(NUM_CORES),
    parameter int PERF_CTR_BITS = GBAR_DEF_PERF_BITS
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_CORES-1:0]          req_valid,
    input  logic [NUM_CORES*NB_WIDTH-1:0] req_id,
    input  logic [NUM_CORES*NC_WIDTH-1:0] req_size_m1,
    output logic [NUM_CORES-1:0]          req_ready,
    output logic                          rsp_valid,
    output logic [NB_WIDTH-1:0]           rsp_id,
    output logic                          err_dup
`ifdef GBAR_PERF_EN
    ,
    output logic [PERF_CTR_BITS-1:0]      perf_releases,
    output logic [PERF_CTR_BITS-1:0]      perf_stall_cycles
`endif
);

    localparam int CNT_W = $clog2(NUM_CORES + 1);
    // Comparison width covers both the arrival count and size_m1+1 without
    // overflow (size_m1+1 can reach 2**NC_WIDTH).
    localparam int CMP_W = ((CNT_W > NC_WIDTH) ? CNT_W : NC_WIDTH) + 1;

    typedef struct packed {
        logic [NB_WIDTH-1:0] id;
        logic [NC_WIDTH-1:0] size_m1;
    } req_t;

    // ---------------------------------------------------------------- unpack
    req_t w_req [NUM_CORES];

    for (genvar c = 0; c < NUM_CORES; c++) begin : g_unpack
        assign w_req[c].id      = req_id[c*NB_WIDTH +: NB_WIDTH];
        assign w_req[c].size_m1 = req_size_m1[c*NC_WIDTH +: NC_WIDTH];
    end

    // ------------------------------------------------------------ arbitration
    logic [NUM_CORES-1:0] w_grant;
    logic [NC_WIDTH-1:0]  w_gidx;
    logic                 w_gvalid;
    logic                 w_fire;

    vx_gbar_rr_arb #(
        .N  (NUM_CORES),
        .IW (NC_WIDTH)
    ) u_rr_arb (
        .clk           (clk),
        .reset         (reset),
        .i_valid       (req_valid),
        .i_fire        (w_fire),
        .o_grant       (w_grant),
        .o_grant_idx   (w_gidx),
        .o_grant_valid (w_gvalid)
    );

    // The grant is only ever raised on a valid requester, so a granted
    // request always fires; there is no second handshake to wait on.
    assign req_ready = w_grant;
    assign w_fire    = w_gvalid;

    // -------------------------------------------------------- arrival tracking
    logic [NUM_CORES-1:0] r_mask [NUM_BARRIERS];
    req_t                 w_sel;
    logic [NUM_CORES-1:0] w_cur;
    logic [NUM_CORES-1:0] w_new;
    logic [CNT_W-1:0]     w_cnt;
    logic                 w_dup;
    logic                 w_done;

    assign w_sel = w_req[w_gidx];
    assign w_cur = r_mask[w_sel.id];
    assign w_new = w_cur | w_grant;
    assign w_dup = |(w_cur & w_grant);

    always_comb begin
        w_cnt = '0;
        for (int c = 0; c < NUM_CORES; c++) begin
            w_cnt = w_cnt + CNT_W'(w_new[c]);
        end
    end

    assign w_done = (CMP_W'(w_cnt) >= (CMP_W'(w_sel.size_m1) + CMP_W'(1)));

    // A duplicate arrival leaves the mask alone but can still complete the
    // barrier if the other cores have already filled it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int b = 0; b < NUM_BARRIERS; b++) r_mask[b] <= '0;
        end else if (w_fire) begin
            if (w_done)
                r_mask[w_sel.id] <= '0;
            else if (!w_dup)
                r_mask[w_sel.id] <= w_new;
        end
    end

    // -------------------------------------------------------------- response
    logic                r_rsp_valid;
    logic [NB_WIDTH-1:0] r_rsp_id;
    logic                r_err_dup;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rsp_valid <= 1'b0;
            r_rsp_id    <= '0;
            r_err_dup   <= 1'b0;
        end else begin
            r_rsp_valid <= w_fire && w_done;
            if (w_fire && w_done) r_rsp_id <= w_sel.id;
            if (w_fire && w_dup)  r_err_dup <= 1'b1;
        end
    end

    assign rsp_valid = r_rsp_valid;
    assign rsp_id    = r_rsp_id;
    assign err_dup   = r_err_dup;

`ifdef GBAR_PERF_EN
    // ---------------------------------------------------------- perf counters
    logic [PERF_CTR_BITS-1:0] r_perf_rel;
    logic [PERF_CTR_BITS-1:0] r_perf_stall;
    logic [CNT_W-1:0]         w_nreq;

    always_comb begin
        w_nreq = '0;
        for (int c = 0; c < NUM_CORES; c++) begin
            w_nreq = w_nreq + CNT_W'(req_valid[c]);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_perf_rel   <= '0;
            r_perf_stall <= '0;
        end else begin
            if (r_rsp_valid)           r_perf_rel   <= r_perf_rel + 1'b1;
            if (w_nreq > CNT_W'(1))    r_perf_stall <= r_perf_stall + 1'b1;
        end
    end

    assign perf_releases     = r_perf_rel;
    assign perf_stall_cycles = r_perf_stall;
`endif

endmodule

// File: tb/tb_vx_gbar_arbiter.sv
// -----------------------------------------------------------------------------
// tb_vx_gbar_arbiter
// Directed stimulus for the global barrier controller (4 cores, 8 barriers).
// Each completing arrival pushes {id, release cycle} into a queue; a monitor
// pops an entry on every rsp_valid pulse and checks id and timing. Grants and
// err_dup are checked inline by the stimulus.
// -----------------------------------------------------------------------------
module tb_vx_gbar_arbiter;

    localparam int NC = 4;
    localparam int NB = 8;
    localparam int BW = 3;
    localparam int SW = 2;

    logic              clk;
    logic              reset;
    logic [NC-1:0]     req_valid;
    logic [NC*BW-1:0]  req_id;
    logic [NC*SW-1:0]  req_size_m1;
    logic [NC-1:0]     req_ready;
    logic              rsp_valid;
    logic [BW-1:0]     rsp_id;
    logic              err_dup;
`ifdef GBAR_PERF_EN
    logic [43:0]       perf_releases;
    logic [43:0]       perf_stall_cycles;
`endif

    vx_gbar_arbiter #(
        .NUM_CORES    (NC),
        .NUM_BARRIERS (NB)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .req_valid         (req_valid),
        .req_id            (req_id),
        .req_size_m1       (req_size_m1),
        .req_ready         (req_ready),
        .rsp_valid         (rsp_valid),
        .rsp_id            (rsp_id),
        .err_dup           (err_dup)
`ifdef GBAR_PERF_EN
        ,
        .perf_releases     (perf_releases),
        .perf_stall_cycles (perf_stall_cycles)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_pass = 0;
    int n_tot  = 0;

    typedef struct {
        int id;
        int cyc;
    } exp_t;
    exp_t q[$];

    task automatic chk(input string nm, input longint act, input longint exp);
        n_tot++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
    endtask

    // Set one core's request lines.
    task automatic drv(input int c, input bit v, input int id, input int s);
        req_valid[c]          = v;
        req_id[c*BW +: BW]    = BW'(id);
        req_size_m1[c*SW +: SW] = SW'(s);
    endtask

    // One cycle: check the grant vector mid-cycle, record an expected release
    // if this grant completes a barrier, then move to just past the edge.
    task automatic tick(input logic [NC-1:0] exp_ready, input bit rel, input int rid);
        exp_t e;
        @(negedge clk);
        chk("req_ready", req_ready, exp_ready);
        if (rel) begin
            e.id  = rid;
            e.cyc = cyc + 1;
            q.push_back(e);
        end
        @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor.
    always @(negedge clk) begin
        exp_t e;
        if (!reset && rsp_valid) begin
            if (q.size() == 0) begin
                n_tot++;
                $display("FAIL rsp_unexpected: got id %0d at cycle %0d, expected none", rsp_id, cyc);
            end else begin
                e = q.pop_front();
                chk("rsp_id", rsp_id, e.id);
                chk("rsp_cycle", cyc, e.cyc);
            end
        end
    end

    initial begin
        reset       = 1'b1;
        req_valid   = '0;
        req_id      = '0;
        req_size_m1 = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_err_dup", err_dup, 0);
        chk("rst_req_ready", req_ready, 0);
        @(posedge clk); #1;
        reset = 1'b0;

        // Activity that the mid-cycle reset must wipe out.
        drv(0, 1, 4, 1); tick(4'b0001, 0, 0); drv(0, 0, 0, 0);
        drv(1, 1, 6, 3); tick(4'b0010, 0, 0); tick(4'b0010, 0, 0); drv(1, 0, 0, 0);
        chk("pre_err_dup", err_dup, 1);
        drv(2, 1, 4, 1);
        @(negedge clk);
        chk("pre_complete_ready", req_ready, 4'b0100);
        @(posedge clk); #2;
        reset     = 1'b1;
        req_valid = '0;
        #1;
        chk("arst_rsp_valid", rsp_valid, 0);
        chk("arst_err_dup", err_dup, 0);
        chk("arst_req_ready", req_ready, 0);
        @(posedge clk); #1;
        reset = 1'b0;

        // Single arrival after reset: a stale mask[6] would complete here.
        drv(0, 1, 6, 1); tick(4'b0001, 0, 0); drv(0, 0, 0, 0);
        tick(4'b0000, 0, 0);

        // id=2, s=3: arrivals on relative cycles 0,1,2,5 (ptr starts at 1).
        drv(1, 1, 2, 3); tick(4'b0010, 0, 0); drv(1, 0, 0, 0);
        drv(2, 1, 2, 3); tick(4'b0100, 0, 0); drv(2, 0, 0, 0);
        drv(3, 1, 2, 3); tick(4'b1000, 0, 0); drv(3, 0, 0, 0);
        tick(4'b0000, 0, 0);
        tick(4'b0000, 0, 0);
        drv(0, 1, 2, 3); tick(4'b0001, 1, 2); drv(0, 0, 0, 0);

        // mask[2] must be empty again: two fresh arrivals with s=1.
        drv(1, 1, 2, 1); tick(4'b0010, 0, 0); drv(1, 0, 0, 0);
        drv(2, 1, 2, 1); tick(4'b0100, 1, 2); drv(2, 0, 0, 0);

        // s=0 releases on its own arrival; leaves ptr at 0.
        drv(3, 1, 7, 0); tick(4'b1000, 1, 7); drv(3, 0, 0, 0);
        tick(4'b0000, 0, 0);

        // All four cores at once, id=1 s=3, ptr=0.
        for (int c = 0; c < NC; c++) drv(c, 1, 1, 3);
        tick(4'b0001, 0, 0); drv(0, 0, 0, 0);
        tick(4'b0010, 0, 0); drv(1, 0, 0, 0);
        tick(4'b0100, 0, 0); drv(2, 0, 0, 0);
        tick(4'b1000, 1, 1); drv(3, 0, 0, 0);

        // Interleaved ids with back-to-back releases (5 then 0).
        drv(0, 1, 0, 1); drv(1, 1, 5, 1); drv(2, 1, 5, 1); drv(3, 1, 0, 1);
        tick(4'b0001, 0, 0); drv(0, 0, 0, 0);
        tick(4'b0010, 0, 0); drv(1, 0, 0, 0);
        tick(4'b0100, 1, 5); drv(2, 0, 0, 0);
        tick(4'b1000, 1, 0); drv(3, 0, 0, 0);

        // Duplicate arrival by core 1 at id=3 s=2.
        drv(1, 1, 3, 2); tick(4'b0010, 0, 0);
        chk("dup_first_clean", err_dup, 0);
        tick(4'b0010, 0, 0); drv(1, 0, 0, 0);
        chk("dup_sticky", err_dup, 1);
        drv(2, 1, 3, 2); drv(3, 1, 3, 2);
        tick(4'b0100, 0, 0); drv(2, 0, 0, 0);
        tick(4'b1000, 1, 3); drv(3, 0, 0, 0);
        tick(4'b0000, 0, 0);
        tick(4'b0000, 0, 0);
        chk("dup_still_set", err_dup, 1);
        chk("scoreboard_drained", q.size(), 0);
`ifdef GBAR_PERF_EN
        chk("perf_releases", perf_releases, 7);
`endif

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
